draw_rect_bounce: RTL

//  Pixel-stream stage directly downstream of the VGA timing generator (or a bg draw stage).

---
 rtl/vga_pkg.sv | 56 +++++
 rtl/rect_motion.sv | 78 +++++++
 rtl/draw_rect_bounce.sv | 95 +++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA stream types and active-area geometry for the draw-stage chain.
// Also holds the motion FSM states and the per-axis bounce step used by rect_motion.
package vga_pkg;

    localparam int H_Blank_time = 800;
    localparam int V_Blank_time = 600;

    typedef logic [11:0] rgb_t;

    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
    } vga_tim_t;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_COUNT = 2'd1,
        ST_MOVE  = 2'd2
    } motion_state_t;

    // back = 0 means moving towards larger coordinates (right / down)
    typedef struct packed {
        logic [10:0] pos;
        logic        back;
    } axis_t;

    // One bounce step on one axis; sums are 12 bits so pos+size+step cannot wrap.
    function automatic axis_t axis_step(axis_t cur, int unsigned size,
                                        int unsigned step, int unsigned limit);
        axis_t       nxt;
        logic [11:0] far_edge;
        nxt      = cur;
        far_edge = {1'b0, cur.pos} + 12'(size) + 12'(step);
        if (!cur.back) begin
            if (far_edge <= 12'(limit)) begin
                nxt.pos = cur.pos + 11'(step);
            end else begin
                nxt.pos  = 11'(limit - size);
                nxt.back = 1'b1;
            end
        end else begin
            if (cur.pos >= 11'(step)) begin
                nxt.pos = cur.pos - 11'(step);
            end else begin
                nxt.pos  = '0;
                nxt.back = 1'b0;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rect_motion.sv
// Per-frame rectangle motion: divides frame ticks and bounces the position off the active area.
//   state    | meaning
//   ST_WAIT  | idle until an enabled frame tick
//   ST_COUNT | advance frame divider, decide whether this frame moves
//   ST_MOVE  | apply one bounce step on both axes
module rect_motion
    import vga_pkg::*;
#(
    parameter int RECT_W    = 64,
    parameter int RECT_H    = 48,
    parameter int STEP      = 2,
    parameter int FRAME_DIV = 1,
    parameter int X_INIT    = 100,
    parameter int Y_INIT    = 100
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        en,
    output logic [10:0] rect_x,
    output logic [10:0] rect_y
);

    localparam int CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    motion_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    axis_t            x_q, x_d;
    axis_t            y_q, y_d;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            x_q     <= '{pos: 11'(X_INIT), back: 1'b0};
            y_q     <= '{pos: 11'(Y_INIT), back: 1'b0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_WAIT: begin
                if (frame_tick && en) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_MOVE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_MOVE: begin
                x_d     = axis_step(x_q, RECT_W, STEP, H_Blank_time);
                y_d     = axis_step(y_q, RECT_H, STEP, V_Blank_time);
                state_d = ST_WAIT;
            end
            default: state_d = ST_WAIT;
        endcase
    end

    assign rect_x = x_q.pos;
    assign rect_y = y_q.pos;

endmodule

// File: rtl/draw_rect_bounce.sv
// Draw stage: overlays a bouncing solid rectangle on the pixel stream,
// delaying all timing signals by one cycle to stay aligned with rgb_out.
module draw_rect_bounce
    import vga_pkg::*;
#(
    parameter int   RECT_W     = 64,
    parameter int   RECT_H     = 48,
    parameter int   X_INIT     = 100,
    parameter int   Y_INIT     = 100,
    parameter int   STEP       = 2,
    parameter int   FRAME_DIV  = 1,
    parameter rgb_t RECT_COLOR = 12'hF80
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        en,
    input  logic [10:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [10:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [10:0] rect_x,
    output logic [10:0] rect_y
);

    vga_tim_t tim_q, tim_d;
    rgb_t     rgb_q, rgb_d;
    logic     vblnk_prev_q;
    logic     frame_tick;
    logic     in_x, in_y;

    assign frame_tick = vblnk_in & ~vblnk_prev_q;

    rect_motion #(
        .RECT_W    (RECT_W),
        .RECT_H    (RECT_H),
        .STEP      (STEP),
        .FRAME_DIV (FRAME_DIV),
        .X_INIT    (X_INIT),
        .Y_INIT    (Y_INIT)
    ) u_motion (
        .pclk       (pclk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .en         (en),
        .rect_x     (rect_x),
        .rect_y     (rect_y)
    );

    always_comb begin
        tim_d = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                  vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};
        in_x  = ({1'b0, hcount_in} >= {1'b0, rect_x}) &&
                ({1'b0, hcount_in} <  ({1'b0, rect_x} + 12'(RECT_W)));
        in_y  = ({1'b0, vcount_in} >= {1'b0, rect_y}) &&
                ({1'b0, vcount_in} <  ({1'b0, rect_y} + 12'(RECT_H)));
        if (hblnk_in || vblnk_in) begin
            rgb_d = 12'h000;
        end else if (in_x && in_y) begin
            rgb_d = RECT_COLOR;
        end else begin
            rgb_d = rgb_in;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            tim_q        <= '0;
            rgb_q        <= '0;
            vblnk_prev_q <= 1'b0;
        end else begin
            tim_q        <= tim_d;
            rgb_q        <= rgb_d;
            vblnk_prev_q <= vblnk_in;
        end
    end

    assign hcount_out = tim_q.hcount;
    assign hsync_out  = tim_q.hsync;
    assign hblnk_out  = tim_q.hblnk;
    assign vcount_out = tim_q.vcount;
    assign vsync_out  = tim_q.vsync;
    assign vblnk_out  = tim_q.vblnk;
    assign rgb_out    = rgb_q;

endmodule
